// File: rtl/div_pkg.sv
// div_pkg: shared op encodings, special-result codes, FSM states and queue control fields for the divide unit
package div_pkg;
    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;
    typedef enum logic [1:0] {NORMAL, DZ, OVF} spec_e;
    typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, OUT} state_e;
    typedef struct packed {
        logic  q_neg;
        logic  r_neg;
        logic  is_rem;
        spec_e spec;
    } ctl_t;
endpackage

// File: rtl/div_core_iter.sv
// div_core_iter: unsigned restoring divider retiring RB quotient bits per cycle on an XLEN+1-bit partial remainder
module div_core_iter #(
    parameter int XLEN = 32,
    parameter int RB = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] q,
    output logic [XLEN-1:0] r
);
    localparam int N = XLEN / RB;
    localparam int CW = $clog2(N + 1);
    logic [XLEN-1:0] pr_q, pr_d, dq_q, dq_d, dv_q;
    logic [XLEN:0] w;
    logic ge;
    logic [CW-1:0] cnt_q;
    // dq holds the unconsumed dividend bits on top and the quotient bits shifted in below
    always_comb begin
        w = {1'b0, pr_q};
        dq_d = dq_q;
        ge = 1'b0;
        for (int i = 0; i < RB; i++) begin
            w = {w[XLEN-1:0], dq_d[XLEN-1]};
            ge = w >= {1'b0, dv_q};
            w = ge ? w - {1'b0, dv_q} : w;
            dq_d = {dq_d[XLEN-2:0], ge};
        end
        pr_d = w[XLEN-1:0];
        done = cnt_q == CW'(1);
        q = dq_q;
        r = pr_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pr_q <= '0;
            dq_q <= '0;
            dv_q <= '0;
            cnt_q <= '0;
        end else if (!hold) begin
            if (start) begin
                pr_q <= '0;
                dq_q <= dividend;
                dv_q <= divisor;
                cnt_q <= CW'(N);
            end else if (cnt_q != '0) begin
                pr_q <= pr_d;
                dq_q <= dq_d;
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end
endmodule

// File: rtl/div_unit_param.sv
// div_unit_param: queued in-order DIV/DIVU/REM/REMU unit with RISC-V special results, pause and flush
module div_unit_param
    import div_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RB = 2,
    parameter int QDEPTH = 4,
    parameter int TAG_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pause,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out_data,
    output logic             busy
);
    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(QDEPTH);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
    typedef struct packed {
        ctl_t ctl;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } entry_t;
    entry_t mem_q [QDEPTH];
    entry_t cur_q, in_e;
    logic [PW-1:0] wp_q, rp_q;
    logic [PW:0] cnt_q;
    state_e st_q, st_d;
    logic [XLEN-1:0] out_data_q, q_mag, q_val, r_mag, r_val, core_q, core_r;
    logic [TAG_W-1:0] out_tag_q;
    logic sgn, s1, s2, enq, deq, core_done, core_start;
    always_comb begin
        sgn = in_op == OP_DIV || in_op == OP_REM;
        s1 = sgn & in_rs1[XLEN-1];
        s2 = sgn & in_rs2[XLEN-1];
        in_e.ctl.q_neg = s1 ^ s2;
        in_e.ctl.r_neg = s1;
        in_e.ctl.is_rem = in_op == OP_REM || in_op == OP_REMU;
        in_e.ctl.spec = ~|in_rs2 ? DZ : (sgn && in_rs1 == SMIN && &in_rs2) ? OVF : NORMAL;
        in_e.tag = in_tag;
        in_e.a = s1 ? -in_rs1 : in_rs1;
        in_e.b = s2 ? -in_rs2 : in_rs2;
        in_ready = cnt_q != CNT_FULL;
        enq = in_valid & in_ready & ~pause & ~flush;
        deq = st_q == IDLE && cnt_q != '0 && !pause && !flush;
        core_start = st_q == LOAD && cur_q.ctl.spec == NORMAL;
        st_d = st_q == IDLE ? (cnt_q != '0 ? LOAD : IDLE) :
               st_q == LOAD ? (cur_q.ctl.spec == NORMAL ? ITER : FIX) :
               st_q == ITER ? (core_done ? FIX : ITER) :
               st_q == FIX  ? OUT : IDLE;
        // special codes bypass the core: DZ keeps |rs1| for the remainder, OVF returns rs1 as quotient
        q_mag = cur_q.ctl.spec == OVF ? cur_q.a : core_q;
        q_val = cur_q.ctl.spec == DZ ? '1 : cur_q.ctl.q_neg ? -q_mag : q_mag;
        r_mag = cur_q.ctl.spec == DZ ? cur_q.a : cur_q.ctl.spec == OVF ? '0 : core_r;
        r_val = cur_q.ctl.r_neg ? -r_mag : r_mag;
        out_valid = st_q == OUT && !pause && !flush;
        out_tag = out_tag_q;
        out_data = out_data_q;
        busy = cnt_q != '0 || st_q != IDLE;
    end
    always_ff @(posedge clk) begin
        if (enq) mem_q[wp_q] <= in_e;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
            cur_q <= '0;
            out_tag_q <= '0;
            out_data_q <= '0;
            st_q <= IDLE;
        end else if (flush) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
            st_q <= IDLE;
        end else if (!pause) begin
            if (enq) wp_q <= wp_q + 1'b1;
            if (deq) begin
                cur_q <= mem_q[rp_q];
                rp_q <= rp_q + 1'b1;
            end
            cnt_q <= cnt_q + (PW+1)'(enq) - (PW+1)'(deq);
            if (st_q == FIX) begin
                out_data_q <= cur_q.ctl.is_rem ? r_val : q_val;
                out_tag_q <= cur_q.tag;
            end
            st_q <= st_d;
        end
    end
    div_core_iter #(.XLEN(XLEN), .RB(RB)) u_core (
        .clk(clk),
        .reset(reset | flush),
        .hold(pause),
        .start(core_start),
        .dividend(cur_q.a),
        .divisor(cur_q.b),
        .done(core_done),
        .q(core_q),
        .r(core_r)
    );
endmodule

// File: tb/tb_div_unit_param.sv
// tb_div_unit_param: directed and randomized checks of div_unit_param against an arithmetic reference model
module tb_div_unit_param;
    logic clk = 0, reset = 1, pause = 0, flush = 0;
    logic a_in_valid = 0, a_in_ready, a_out_valid, a_busy;
    logic [1:0] a_op = 0;
    logic [31:0] a_rs1 = 0, a_rs2 = 0, a_out_data;
    logic [6:0] a_tag = 0, a_out_tag;
    logic b_in_valid = 0, b_in_ready, b_out_valid, b_busy;
    logic [1:0] b_op = 0;
    logic [15:0] b_rs1 = 0, b_rs2 = 0, b_out_data;
    logic [6:0] b_tag = 0, b_out_tag;
    logic c_in_valid = 0, c_in_ready, c_out_valid, c_busy;
    logic [1:0] c_op = 0;
    logic [23:0] c_rs1 = 0, c_rs2 = 0, c_out_data;
    logic [6:0] c_tag = 0, c_out_tag;
    int n_tests = 0, n_fail = 0;
    logic [38:0] a_q[$], b_q[$], c_q[$];
    logic [38:0] e;
    logic [1:0] op;
    logic [31:0] x, y, ex;
    int lat, sent, got, acc_full, cyc, seen, bi, ci, bg, cg;

    always #5 clk = ~clk;

    div_unit_param #(.XLEN(32), .RB(2), .QDEPTH(4), .TAG_W(7)) dut_a (
        .clk(clk), .reset(reset), .pause(pause), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_op), .in_rs1(a_rs1), .in_rs2(a_rs2),
        .in_tag(a_tag), .out_valid(a_out_valid), .out_tag(a_out_tag), .out_data(a_out_data), .busy(a_busy));
    div_unit_param #(.XLEN(16), .RB(1), .QDEPTH(4), .TAG_W(7)) dut_b (
        .clk(clk), .reset(reset), .pause(pause), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_op), .in_rs1(b_rs1), .in_rs2(b_rs2),
        .in_tag(b_tag), .out_valid(b_out_valid), .out_tag(b_out_tag), .out_data(b_out_data), .busy(b_busy));
    div_unit_param #(.XLEN(24), .RB(3), .QDEPTH(4), .TAG_W(7)) dut_c (
        .clk(clk), .reset(reset), .pause(pause), .flush(flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_op(c_op), .in_rs1(c_rs1), .in_rs2(c_rs2),
        .in_tag(c_tag), .out_valid(c_out_valid), .out_tag(c_out_tag), .out_data(c_out_data), .busy(c_busy));

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // RISC-V division semantics on w-bit operands, computed with wide signed arithmetic
    function automatic logic [31:0] ref_div(input int w, input logic [1:0] o, input logic [31:0] p, input logic [31:0] d);
        longint m, sx, sy, qq, rr;
        m = (longint'(1) << w) - 1;
        sx = longint'(p) & m;
        sy = longint'(d) & m;
        if (!o[0]) begin
            if (sx >= (longint'(1) << (w - 1))) sx = sx - (longint'(1) << w);
            if (sy >= (longint'(1) << (w - 1))) sy = sy - (longint'(1) << w);
        end
        if (sy == 0) begin
            qq = -1;
            rr = sx;
        end else if (!o[0] && sx == -(longint'(1) << (w - 1)) && sy == -1) begin
            qq = sx;
            rr = 0;
        end else begin
            qq = sx / sy;
            rr = sx % sy;
        end
        return 32'((o[1] ? rr : qq) & m);
    endfunction

    task automatic gen(input int w, output logic [1:0] o, output logic [31:0] p, output logic [31:0] d);
        logic [31:0] m;
        int s;
        m = 32'((longint'(1) << w) - 1);
        o = 2'($urandom_range(0, 3));
        p = $urandom & m;
        d = $urandom & m;
        s = $urandom_range(0, 9);
        if (s == 0) d = 0;
        else if (s == 1) begin
            p = 32'(1) << (w - 1);
            d = m;
        end else if (s == 2) d = $urandom_range(1, 7);
        else if (s == 3) p = $urandom_range(0, 50);
    endtask

    task automatic send_a(input logic [1:0] o, input logic [31:0] p, input logic [31:0] d, input logic [6:0] t);
        a_in_valid = 1;
        a_op = o;
        a_rs1 = p;
        a_rs2 = d;
        a_tag = t;
        @(negedge clk);
        a_in_valid = 0;
    endtask

    task automatic wait_a(input int start, input int maxc, output int l);
        l = start;
        while (!a_out_valid && l < maxc) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic directed(input string name, input logic [1:0] o, input logic [31:0] p, input logic [31:0] d,
                            input logic [6:0] t, input logic [31:0] exp, input int exp_lat);
        int l;
        send_a(o, p, d, t);
        wait_a(1, 60, l);
        chk({name, "_lat"}, l, exp_lat);
        chk({name, "_data"}, a_out_data, exp);
        chk({name, "_tag"}, a_out_tag, t);
        @(negedge clk);
        chk({name, "_pulse"}, a_out_valid, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_tag", a_out_tag, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_b_busy", b_busy, 0);

        directed("div_m7_2", 2'd0, 32'hFFFFFFF9, 32'd2, 7'd5, 32'hFFFFFFFD, 20);
        directed("rem_m7_2", 2'd2, 32'hFFFFFFF9, 32'd2, 7'd6, 32'hFFFFFFFF, 20);
        directed("divu_dz", 2'd1, 32'hFFFFFFFF, 32'd0, 7'd7, 32'hFFFFFFFF, 4);
        directed("remu_dz", 2'd3, 32'd100, 32'd0, 7'd8, 32'd100, 4);
        directed("div_ovf", 2'd0, 32'h80000000, 32'hFFFFFFFF, 7'd9, 32'h80000000, 4);
        directed("rem_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 7'd10, 32'd0, 4);
        directed("div_sdz", 2'd0, 32'hFFFFFFFB, 32'd0, 7'd11, 32'hFFFFFFFF, 4);
        directed("rem_sdz", 2'd2, 32'hFFFFFFFB, 32'd0, 7'd12, 32'hFFFFFFFB, 4);
        chk("idle_busy", a_busy, 0);

        // six ops with in_valid held: queue fills while the head is in the core
        sent = 0; got = 0; acc_full = -1; cyc = 0;
        gen(32, op, x, y);
        while (got < 6 && cyc < 400) begin
            if (a_out_valid) begin
                if (a_q.size() == 0) chk("b2b_spurious", 1, 0);
                else begin
                    e = a_q.pop_front();
                    chk("b2b_tag", a_out_tag, e[38:32]);
                    chk("b2b_data", a_out_data, e[31:0]);
                end
                got++;
            end
            if (sent < 6) begin
                a_in_valid = 1; a_op = op; a_rs1 = x; a_rs2 = y; a_tag = 7'(20 + sent);
                if (a_in_ready) begin
                    a_q.push_back({a_tag, ref_div(32, op, x, y)});
                    sent++;
                    gen(32, op, x, y);
                end else if (acc_full < 0) acc_full = sent;
            end else a_in_valid = 0;
            @(negedge clk);
            cyc++;
        end
        a_in_valid = 0;
        chk("b2b_full_at", acc_full, 5);
        chk("b2b_count", got, 6);

        // pause for 3 cycles mid-ITER, then again while the result is presented
        x = $urandom;
        y = $urandom_range(1, 1000);
        ex = ref_div(32, 2'd1, x, y);
        send_a(2'd1, x, y, 7'd30);
        repeat (5) @(negedge clk);
        pause = 1;
        repeat (3) @(negedge clk);
        pause = 0;
        wait_a(9, 80, lat);
        chk("pause_lat", lat, 23);
        chk("pause_data", a_out_data, ex);
        pause = 1;
        #1 chk("pause_masked0", a_out_valid, 0);
        repeat (2) begin
            @(negedge clk);
            chk("pause_masked", a_out_valid, 0);
        end
        pause = 0;
        #1 chk("pause_repr", a_out_valid, 1);
        chk("pause_repr_data", a_out_data, ex);
        chk("pause_repr_tag", a_out_tag, 30);
        @(negedge clk);
        chk("pause_single", a_out_valid, 0);
        chk("pause_idle", a_busy, 0);

        // flush with three ops queued and one in ITER; a same-cycle enqueue is dropped
        send_a(2'd1, 32'd1000, 32'd7, 7'd40);
        send_a(2'd0, 32'd55, 32'd5, 7'd41);
        send_a(2'd3, 32'd77, 32'd0, 7'd42);
        send_a(2'd2, 32'd99, 32'd4, 7'd43);
        chk("flush_pre_busy", a_busy, 1);
        flush = 1;
        a_in_valid = 1; a_op = 2'd1; a_rs1 = 32'd8; a_rs2 = 32'd2; a_tag = 7'd44;
        #1 chk("flush_out_masked", a_out_valid, 0);
        @(negedge clk);
        flush = 0;
        a_in_valid = 0;
        chk("flush_busy", a_busy, 0);
        chk("flush_ready", a_in_ready, 1);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (a_out_valid) seen++;
        end
        chk("flush_no_out", seen, 0);
        directed("post_flush", 2'd1, 32'd9, 32'd3, 7'd45, 32'd3, 20);

        // random sweep on the 16/1 and 24/3 instances in parallel
        bi = 0; ci = 0; bg = 0; cg = 0; cyc = 0;
        while ((bg < 1000 || cg < 1000) && cyc < 60000) begin
            if (b_out_valid) begin
                if (b_q.size() == 0) chk("sweep_b_spurious", 1, 0);
                else begin
                    e = b_q.pop_front();
                    chk("sweep_b_tag", b_out_tag, e[38:32]);
                    chk("sweep_b_data", 64'(b_out_data), 64'(e[31:0]));
                end
                bg++;
            end
            if (c_out_valid) begin
                if (c_q.size() == 0) chk("sweep_c_spurious", 1, 0);
                else begin
                    e = c_q.pop_front();
                    chk("sweep_c_tag", c_out_tag, e[38:32]);
                    chk("sweep_c_data", 64'(c_out_data), 64'(e[31:0]));
                end
                cg++;
            end
            b_in_valid = 0;
            if (bi < 1000 && $urandom_range(0, 3) != 0) begin
                gen(16, op, x, y);
                b_in_valid = 1; b_op = op; b_rs1 = x[15:0]; b_rs2 = y[15:0]; b_tag = 7'($urandom);
                if (b_in_ready) begin
                    b_q.push_back({b_tag, ref_div(16, op, x, y)});
                    bi++;
                end
            end
            c_in_valid = 0;
            if (ci < 1000 && $urandom_range(0, 3) != 0) begin
                gen(24, op, x, y);
                c_in_valid = 1; c_op = op; c_rs1 = x[23:0]; c_rs2 = y[23:0]; c_tag = 7'($urandom);
                if (c_in_ready) begin
                    c_q.push_back({c_tag, ref_div(24, op, x, y)});
                    ci++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        b_in_valid = 0;
        c_in_valid = 0;
        chk("sweep_b_count", bg, 1000);
        chk("sweep_c_count", cg, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
